dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 39 +++
 rtl/dmem_responder_tx_fifo.sv | 70 +++++++
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-side memory responder: DMType codes, MMIO map
// and STATUS layout, plus store-legality helpers used by the decoder.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100
    } dm_type_e;

    localparam logic [4:0] MMIO_TX_DATA  = 5'h00;
    localparam logic [4:0] MMIO_STATUS   = 5'h04;
    localparam logic [4:0] MMIO_CYCLE_LO = 5'h08;
    localparam logic [4:0] MMIO_CYCLE_HI = 5'h0C;
    localparam logic [4:0] MMIO_LED      = 5'h10;

    localparam int STATUS_MISALIGN_BIT = 0;
    localparam int STATUS_OVERFLOW_BIT = 1;
    localparam int STATUS_FULL_BIT     = 2;
    localparam int STATUS_COUNT_LSB    = 3;

    function automatic logic dm_is_legal(input logic [2:0] t);
        return t <= 3'b100;
    endfunction

    function automatic logic dm_is_misaligned(input logic [2:0] t, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (t)
            DM_WORD:             mis = (a != 2'b00);
            DM_HALF, DM_HALF_U:  mis = a[0];
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte TX FIFO: circular buffer whose head byte and valid are registered so
// the sink sees glitch-free outputs. The owner gates pushes and tracks overflow.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [7:0]               head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_pop, do_push;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign valid = valid_q;
    assign head  = head_q;
    assign count = count_q;

    // The new head is the freshly pushed byte only when it lands in the slot
    // the read pointer is about to point at; otherwise it comes from storage.
    always_comb begin
        do_pop  = pop && valid_q;
        do_push = push && (!full || do_pop);
        rd_d    = rd_q + PTR_W'(do_pop);
        wr_d    = wr_q + PTR_W'(do_push);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        valid_d = (count_d != '0);
        head_d  = head_q;
        if (valid_d) begin
            head_d = (do_push && (rd_d == wr_q)) ? push_data : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage target for the RV32 core: word RAM with lane handling and load
// extension, plus an MMIO block (TX FIFO, cycle counter, LED, sticky errors).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType_in,
    output logic [31:0] Data_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [15:0] led_out,
    output logic        err_out
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    logic [31:0]      ram_q [RAM_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic             is_mmio;
    logic [4:0]       mmio_off;
    logic             type_legal, store_bad, store_ok, ram_we, mmio_we;
    logic [3:0]       byte_en;
    logic [31:0]      ram_wdata, ram_word, ram_rdata, mmio_rdata, status_word;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic             fifo_push, fifo_pop, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             misalign_q, misalign_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      led_q, led_d;
    logic [63:0]      cycle_q, cycle_d;
    logic             unused_addr;

    assign ram_idx     = Addr_in[IDX_W+1:2];
    assign is_mmio     = Addr_in[31];
    assign mmio_off    = Addr_in[4:0];
    assign unused_addr = ^Addr_in[30:IDX_W+2];

    // Store decode: illegal or misaligned stores are dropped everywhere.
    always_comb begin
        type_legal = dm_is_legal(DMType_in);
        store_bad  = mem_w && (!type_legal || dm_is_misaligned(DMType_in, Addr_in[1:0]));
        store_ok   = mem_w && !store_bad;
        ram_we     = store_ok && !is_mmio;
        mmio_we    = store_ok && is_mmio;
        byte_en    = 4'b0000;
        ram_wdata  = Data_in;
        case (DMType_in)
            DM_WORD: byte_en = 4'b1111;
            DM_HALF, DM_HALF_U: begin
                byte_en   = Addr_in[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{Data_in[15:0]}};
            end
            DM_BYTE, DM_BYTE_U: begin
                byte_en   = 4'b0001 << Addr_in[1:0];
                ram_wdata = {4{Data_in[7:0]}};
            end
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ram_word = ram_q[ram_idx];
        case (Addr_in[1:0])
            2'd0:    lane_byte = ram_word[7:0];
            2'd1:    lane_byte = ram_word[15:8];
            2'd2:    lane_byte = ram_word[23:16];
            default: lane_byte = ram_word[31:24];
        endcase
        lane_half = Addr_in[1] ? ram_word[31:16] : ram_word[15:0];
        case (DMType_in)
            DM_WORD:   ram_rdata = ram_word;
            DM_HALF:   ram_rdata = {{16{lane_half[15]}}, lane_half};
            DM_HALF_U: ram_rdata = {16'b0, lane_half};
            DM_BYTE:   ram_rdata = {{24{lane_byte[7]}}, lane_byte};
            DM_BYTE_U: ram_rdata = {24'b0, lane_byte};
            default:   ram_rdata = '0;
        endcase
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_MISALIGN_BIT]    = misalign_q;
        status_word[STATUS_OVERFLOW_BIT]    = overflow_q;
        status_word[STATUS_FULL_BIT]        = fifo_full;
        status_word[STATUS_COUNT_LSB +: 3]  = 3'(fifo_count);
        case (mmio_off)
            MMIO_STATUS:   mmio_rdata = status_word;
            MMIO_CYCLE_LO: mmio_rdata = cycle_q[31:0];
            MMIO_CYCLE_HI: mmio_rdata = cycle_q[63:32];
            MMIO_LED:      mmio_rdata = {16'b0, led_q};
            default:       mmio_rdata = '0;
        endcase
        if (!type_legal) begin
            Data_out = '0;
        end else if (is_mmio) begin
            Data_out = mmio_rdata;
        end else begin
            Data_out = ram_rdata;
        end
    end

    // A TX push into a full FIFO still succeeds if the head drains this cycle.
    always_comb begin
        misalign_d = misalign_q;
        overflow_d = overflow_q;
        led_d      = led_q;
        cycle_d    = cycle_q + 64'd1;
        fifo_pop   = tx_valid && tx_ready;
        fifo_push  = 1'b0;
        if (store_bad) begin
            misalign_d = 1'b1;
        end
        if (mmio_we) begin
            case (mmio_off)
                MMIO_TX_DATA: begin
                    if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                MMIO_STATUS: begin
                    misalign_d = 1'b0;
                    overflow_d = 1'b0;
                end
                MMIO_LED: led_d = Data_in[15:0];
                default: led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
            overflow_q <= 1'b0;
            led_q      <= '0;
            cycle_q    <= '0;
        end else begin
            misalign_q <= misalign_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            cycle_q    <= cycle_d;
        end
    end

    tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (Data_in[7:0]),
        .pop       (fifo_pop),
        .valid     (tx_valid),
        .head      (tx_data),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign led_out = led_q;
    assign err_out = misalign_q | overflow_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized
// run, all checked against a byte-array / queue reference model.
module tb_dmem_responder;

    localparam int RAM_WORDS = 1024;
    localparam int TX_DEPTH  = 4;
    localparam logic [2:0] T_W = 3'd0, T_H = 3'd1, T_HU = 3'd2, T_B = 3'd3, T_BU = 3'd4;
    localparam logic [31:0] A_TX = 32'h8000_0000, A_ST = 32'h8000_0004;
    localparam logic [31:0] A_LO = 32'h8000_0008, A_HI = 32'h8000_000C, A_LED = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] Addr_in = '0;
    logic [31:0] Data_in = '0;
    logic [2:0]  DMType_in = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] Data_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [15:0] led_out;
    logic        err_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl_ram [RAM_WORDS*4];
    logic [7:0]  mdl_q [$];
    logic        mdl_mis, mdl_ovf;
    logic [15:0] mdl_led;
    logic [63:0] mdl_cyc;

    dmem_responder #(
        .RAM_WORDS(RAM_WORDS),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_w     (mem_w),
        .Addr_in   (Addr_in),
        .Data_in   (Data_in),
        .DMType_in (DMType_in),
        .Data_out  (Data_out),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .led_out   (led_out),
        .err_out   (err_out)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [2:0] t);
        return t <= 3'd4;
    endfunction

    function automatic logic misal(input logic [2:0] t, input logic [1:0] a);
        return (t == T_W && a != 2'b00) || ((t == T_H || t == T_HU) && a[0]);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] t);
        int a, wb, hb;
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        if (!legal(t)) return 32'h0;
        if (addr[31]) begin
            case (addr[4:0])
                5'h04: return {26'b0, 3'(mdl_q.size()), (mdl_q.size() == TX_DEPTH), mdl_ovf, mdl_mis};
                5'h08: return mdl_cyc[31:0];
                5'h0C: return mdl_cyc[63:32];
                5'h10: return {16'b0, mdl_led};
                default: return 32'h0;
            endcase
        end
        a  = int'(addr & 32'(RAM_WORDS*4 - 1));
        wb = a & ~3;
        hb = a & ~1;
        w  = {mdl_ram[wb+3], mdl_ram[wb+2], mdl_ram[wb+1], mdl_ram[wb]};
        h  = {mdl_ram[hb+1], mdl_ram[hb]};
        b  = mdl_ram[a];
        case (t)
            T_W:  return w;
            T_H:  return {{16{h[15]}}, h};
            T_HU: return {16'b0, h};
            T_B:  return {{24{b[7]}}, b};
            default: return {24'b0, b};
        endcase
    endfunction

    task automatic mdl_reset();
        mdl_q.delete();
        mdl_mis = 1'b0;
        mdl_ovf = 1'b0;
        mdl_led = '0;
        mdl_cyc = '0;
    endtask

    // Advances one clock with the currently driven inputs and updates the model.
    task automatic step();
        logic s_bad, s_ok, do_pop, do_push;
        logic [7:0] pb;
        int a;
        do_pop  = 1'b0;
        do_push = 1'b0;
        pb      = Data_in[7:0];
        if (rst) begin
            s_bad  = mem_w && (!legal(DMType_in) || misal(DMType_in, Addr_in[1:0]));
            s_ok   = mem_w && !s_bad;
            do_pop = tx_ready && (mdl_q.size() > 0);
            if (s_bad) mdl_mis = 1'b1;
            if (s_ok && Addr_in[31]) begin
                case (Addr_in[4:0])
                    5'h00: begin
                        if (mdl_q.size() < TX_DEPTH || do_pop) do_push = 1'b1;
                        else mdl_ovf = 1'b1;
                    end
                    5'h04: begin
                        mdl_mis = 1'b0;
                        mdl_ovf = 1'b0;
                    end
                    5'h10: mdl_led = Data_in[15:0];
                    default: ;
                endcase
            end
            if (s_ok && !Addr_in[31]) begin
                a = int'(Addr_in & 32'(RAM_WORDS*4 - 1));
                case (DMType_in)
                    T_W: for (int i = 0; i < 4; i++) mdl_ram[(a & ~3) + i] = Data_in[8*i +: 8];
                    T_H, T_HU: begin
                        mdl_ram[a]   = Data_in[7:0];
                        mdl_ram[a+1] = Data_in[15:8];
                    end
                    default: mdl_ram[a] = Data_in[7:0];
                endcase
            end
        end
        @(posedge clk);
        #1;
        if (rst) mdl_cyc = mdl_cyc + 64'd1;
        if (do_pop) void'(mdl_q.pop_front());
        if (do_push) mdl_q.push_back(pb);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        mem_w     = 1'b1;
        Addr_in   = a;
        Data_in   = d;
        DMType_in = t;
        step();
        mem_w     = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                           output logic [31:0] got, output logic [31:0] exp);
        mem_w     = 1'b0;
        Addr_in   = a;
        DMType_in = t;
        #1;
        got = Data_out;
        exp = model_load(a, t);
        step();
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        rst = 1'b0;
        tx_ready = 1'b0;
        mdl_reset();
        step();
        step();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid got=%0b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (led_out !== 16'h0) begin bad++; $display("[TB] FAIL reset_led got=%h want=0000", led_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0b want=0", err_out); end
        rst = 1'b1;
        do_load(A_LO, T_W, got, exp);
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL reset_cycle_lo got=%h want=00000000", got); end
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL reset_status got=%h want=00000000", got); end
    endtask

    task automatic test_ram_lanes();
        logic [31:0] got, exp;
        logic [31:0] addrs1 [6] = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h12, 32'h11};
        logic [2:0]  types1 [6] = '{T_W, T_B, T_H, T_BU, T_HU, T_B};
        logic [31:0] exps1  [6] = '{32'h11223344, 32'h00000011, 32'h00001122, 32'h00000044, 32'h00001122, 32'h00000033};
        logic [31:0] addrs2 [5] = '{32'h10, 32'h11, 32'h11, 32'h10, 32'h10};
        logic [2:0]  types2 [5] = '{T_W, T_B, T_BU, T_H, T_HU};
        logic [31:0] exps2  [5] = '{32'h1122FF44, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFF44, 32'h0000FF44};
        do_store(32'h10, 32'h11223344, T_W);
        for (int i = 0; i < 6; i++) begin
            do_load(addrs1[i], types1[i], got, exp);
            total++;
            if (got !== exps1[i]) begin bad++; $display("[TB] FAIL ram_lane_a%0d got=%h want=%h", i, got, exps1[i]); end
        end
        do_store(32'h11, 32'h000000FF, T_B);
        for (int i = 0; i < 5; i++) begin
            do_load(addrs2[i], types2[i], got, exps1[0]);
            total++;
            if (got !== exps2[i]) begin bad++; $display("[TB] FAIL ram_lane_b%0d got=%h want=%h", i, got, exps2[i]); end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] got, exp;
        do_store(32'h12, 32'hDEADBEEF, T_W);
        do_load(32'h10, T_W, got, exp);
        total++; if (got !== 32'h1122FF44) begin bad++; $display("[TB] FAIL misalign_suppressed got=%h want=1122ff44", got); end
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h1) begin bad++; $display("[TB] FAIL misalign_status got=%h want=00000001", got); end
        total++; if (err_out !== 1'b1) begin bad++; $display("[TB] FAIL misalign_err got=%0b want=1", err_out); end
        do_store(A_ST, 32'h0, T_W);
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL misalign_clear got=%h want=00000000", got); end
        total++; if (err_out !== 1'b0) begin bad++; $display("[TB] FAIL misalign_err_clear got=%0b want=0", err_out); end
        do_load(32'h10, 3'b111, got, exp);
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL illegal_load got=%h want=00000000", got); end
        do_store(32'h10, 32'h0, 3'b110);
        do_load(32'h10, T_W, got, exp);
        total++; if (got !== 32'h1122FF44) begin bad++; $display("[TB] FAIL illegal_store_suppressed got=%h want=1122ff44", got); end
        total++; if (err_out !== 1'b1) begin bad++; $display("[TB] FAIL illegal_store_err got=%0b want=1", err_out); end
        do_store(A_ST, 32'h0, T_W);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] got, exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_store(A_TX, 32'h41 + i, T_W);
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h26) begin bad++; $display("[TB] FAIL ovf_status got=%h want=00000026", got); end
        total++; if (err_out !== 1'b1) begin bad++; $display("[TB] FAIL ovf_err got=%0b want=1", err_out); end
        do_store(A_ST, 32'h0, T_W);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(32'h41 + i)) begin
                bad++; $display("[TB] FAIL ovf_drain%0d got=%0b/%h want=1/%h", i, tx_valid, tx_data, 8'(32'h41 + i));
            end
            step();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_empty got=%0b want=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_store(A_TX, 32'h51 + i, T_B);
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h24) begin bad++; $display("[TB] FAIL b2b_full_status got=%h want=00000024", got); end
        total++; if (tx_data !== 8'h51) begin bad++; $display("[TB] FAIL b2b_hold got=%h want=51", tx_data); end
        tx_ready = 1'b1;
        do_store(A_TX, 32'h55, T_W);
        tx_ready = 1'b0;
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h24) begin bad++; $display("[TB] FAIL b2b_status got=%h want=00000024", got); end
        total++; if (err_out !== 1'b0) begin bad++; $display("[TB] FAIL b2b_err got=%0b want=0", err_out); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(32'h52 + i)) begin
                bad++; $display("[TB] FAIL b2b_drain%0d got=%0b/%h want=1/%h", i, tx_valid, tx_data, 8'(32'h52 + i));
            end
            step();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty got=%0b want=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_cycle();
        logic [31:0] got, exp;
        rst = 1'b0;
        mdl_reset();
        step();
        rst = 1'b1;
        for (int i = 0; i < 100; i++) step();
        do_load(A_LO, T_W, got, exp);
        total++; if (got !== 32'd100) begin bad++; $display("[TB] FAIL cycle_lo got=%0d want=100", got); end
        do_load(A_HI, T_W, got, exp);
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL cycle_hi got=%h want=00000000", got); end
        do_load(A_LO, T_W, got, exp);
        total++; if (got !== exp) begin bad++; $display("[TB] FAIL cycle_lo_model got=%0d want=%0d", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_store(A_TX, 32'h61 + i, T_W);
        do_store(A_LED, 32'h0000A5A5, T_W);
        total++; if (led_out !== 16'hA5A5 || tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre got=%h/%0b want=a5a5/1", led_out, tx_valid); end
        Addr_in   = A_ST;
        DMType_in = T_W;
        #2;
        rst = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tx_valid got=%0b want=0", tx_valid); end
        total++; if (led_out !== 16'h0) begin bad++; $display("[TB] FAIL midrst_led got=%h want=0000", led_out); end
        total++; if (Data_out !== 32'h0) begin bad++; $display("[TB] FAIL midrst_status got=%h want=00000000", Data_out); end
        mdl_reset();
        step();
        rst = 1'b1;
        do_load(A_ST, T_W, got, exp);
        total++; if (got !== 32'h0) begin bad++; $display("[TB] FAIL midrst_after got=%h want=00000000", got); end
    endtask

    task automatic test_alias_led();
        logic [31:0] got, exp;
        do_store(32'h0000_1000, 32'hCAFEBABE, T_W);
        do_load(32'h0, T_W, got, exp);
        total++; if (got !== 32'hCAFEBABE) begin bad++; $display("[TB] FAIL alias got=%h want=cafebabe", got); end
        do_store(A_LED, 32'h1234ABCD, T_W);
        total++; if (led_out !== 16'hABCD) begin bad++; $display("[TB] FAIL led_out got=%h want=abcd", led_out); end
        do_load(A_LED, T_W, got, exp);
        total++; if (got !== 32'h0000ABCD) begin bad++; $display("[TB] FAIL led_read got=%h want=0000abcd", got); end
    endtask

    task automatic test_random();
        logic [31:0] got, exp, a;
        logic [4:0]  offs_w [4] = '{5'h00, 5'h04, 5'h10, 5'h14};
        logic [4:0]  offs_r [6] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
        int op;
        for (int i = 0; i < 16; i++) do_store(32'(i * 4), $urandom, T_W);
        for (int n = 0; n < 300; n++) begin
            tx_ready = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                do_load(32'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), got, exp);
                total++; if (got !== exp) begin bad++; $display("[TB] FAIL rnd_ram_load%0d got=%h want=%h", n, got, exp); end
            end else if (op <= 6) begin
                do_store(32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
            end else if (op == 7) begin
                a = A_TX | 32'(offs_w[$urandom_range(0, 3)]) | 32'($urandom_range(0, 1));
                do_store(a, $urandom, 3'($urandom_range(0, 4)));
            end else begin
                do_load(A_TX | 32'(offs_r[$urandom_range(0, 5)]), T_W, got, exp);
                total++; if (got !== exp) begin bad++; $display("[TB] FAIL rnd_mmio_load%0d got=%h want=%h", n, got, exp); end
            end
            total++;
            if (tx_valid !== (mdl_q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_tx_valid%0d got=%0b want=%0b", n, tx_valid, mdl_q.size() != 0); end
            else if (tx_valid && tx_data !== mdl_q[0]) begin bad++; $display("[TB] FAIL rnd_tx_data%0d got=%h want=%h", n, tx_data, mdl_q[0]); end
            total++; if (err_out !== (mdl_mis | mdl_ovf)) begin bad++; $display("[TB] FAIL rnd_err%0d got=%0b want=%0b", n, err_out, mdl_mis | mdl_ovf); end
            total++; if (led_out !== mdl_led) begin bad++; $display("[TB] FAIL rnd_led%0d got=%h want=%h", n, led_out, mdl_led); end
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_ram_lanes();
        test_misalign();
        test_fifo_overflow();
        test_back_to_back();
        test_cycle();
        test_reset_mid();
        test_alias_led();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
